// File: rtl/hwa_pkg.sv
//==============================================================================
// Module   : hwa_pkg
// Purpose  : Shared constants, types and helpers for the HWA output collector.
//            N      - stochastic bit resolution (counts are N+1 bits wide)
//            WIN    - stochastic window length (2^N cycles)
//            NCH    - number of filter channels
//            cnt_t  - unsigned channel count, samp_t - bipolar-decoded sample
//            frame_t- one captured frame: valid mask plus four samples
// Config   : HWA_OUT_SAT_EN - when defined, decode() clamps to the signed
//            N+1-bit range minus the +2^(N-1) code (full count -> 2^(N-1)-1).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package hwa_pkg;

  localparam int N   = 12;
  localparam int WIN = 1 << N;
  localparam int NCH = 4;

  typedef logic        [N:0] cnt_t;
  typedef logic signed [N:0] samp_t;

  typedef struct packed {
    logic  [NCH-1:0] vmask;
    samp_t [NCH-1:0] samp;
  } frame_t;

  // Bipolar decode: a count of 2^(N-1) (half ones) means zero.
  function automatic samp_t decode(input cnt_t cnt);
    int v;
    v = int'(cnt) - (1 << (N - 1));
`ifdef HWA_OUT_SAT_EN
    if (v > (1 << (N - 1)) - 1) begin
      v = (1 << (N - 1)) - 1;
    end
`endif
    return samp_t'(v);
  endfunction

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [1:0] lowest_set(input logic [NCH-1:0] m);
    logic [1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Index of the highest set bit (0 when the mask is empty).
  function automatic logic [1:0] highest_set(input logic [NCH-1:0] m);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hwa_frame_fifo.sv
//==============================================================================
// Module   : hwa_frame_fifo
// Purpose  : Synchronous frame FIFO with registered pointers and full/empty
//            flags. A push and a pop in the same cycle both take effect, so a
//            full FIFO can accept a new entry while its head is released.
// Ports    : clk_i   - clock, rising edge
//            rst_ni  - asynchronous active-low reset (empties the FIFO)
//            push_i  - write data_i this cycle
//            data_i  - entry to write
//            pop_i   - release the head entry this cycle
//            data_o  - head entry (valid while !empty_o)
//            full_o  - DEPTH entries held
//            empty_o - no entries held
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hwa_frame_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/hwa_out_collector.sv
//==============================================================================
// Module   : hwa_out_collector
// Purpose  : Collects the four stochastic channel counts of the HWA filter
//            array once per window, bipolar-decodes them and streams the
//            valid channels of each frame out over a valid/ready interface.
// Ports    : clock    - single clock, rising edge
//            reset_n  - asynchronous active-low reset
//            start    - one-cycle pulse, (re)starts the window counter
//            hwa_out  - four N+1-bit channel counts, channel c at slice c
//            m_valid / m_ready - output handshake
//            m_chan   - channel index of m_data
//            m_data   - signed decoded sample
//            m_last   - highest valid channel of the frame
//            busy     - window counter running
//            overflow - sticky, a frame was dropped on a full FIFO
// Config   : HWA_OUT_SAT_EN - clamp decoded samples to 2^(N-1)-1.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hwa_out_collector
  import hwa_pkg::NCH, hwa_pkg::samp_t, hwa_pkg::frame_t,
         hwa_pkg::decode, hwa_pkg::lowest_set, hwa_pkg::highest_set;
#(
  parameter int N      = hwa_pkg::N,    // frame types follow hwa_pkg::N
  parameter int WIN    = hwa_pkg::WIN,
  parameter int FDEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [NCH*(N+1)-1:0]   hwa_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [1:0]             m_chan,
  output logic signed [N:0]      m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   overflow
);

  localparam int CW = $clog2(WIN);

  // Window counter
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [2:0]    win_done_q, win_done_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          capture;
  logic [2:0]    done_post;

  // Frame path
  frame_t        frame_new;
  frame_t        frame_head;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

  // Serializer
  logic          m_valid_q, m_valid_d;
  logic [1:0]    m_chan_q, m_chan_d;
  samp_t         m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          hs;
  logic          load;
  logic [1:0]    next_chan;
  logic [NCH-1:0] upper_mask;

  assign capture   = busy_q && (win_cnt_q == CW'(WIN - 1));
  assign done_post = (win_done_q == 3'd4) ? 3'd4 : win_done_q + 3'd1;

  // Channel c has passed through c+1 stochastic stages only after c+1
  // complete windows, so earlier captures of it are warm-up garbage.
  always_comb begin
    frame_new = '0;
    for (int c = 0; c < NCH; c++) begin
      frame_new.vmask[c] = (done_post >= 3'(c + 1));
      frame_new.samp[c]  = decode(hwa_out[c*(N+1) +: N+1]);
    end
  end

  always_comb begin
    win_cnt_d  = win_cnt_q;
    win_done_d = win_done_q;
    busy_d     = busy_q;
    if (start) begin
      win_cnt_d  = '0;
      win_done_d = '0;
      busy_d     = 1'b1;
    end else if (busy_q) begin
      win_cnt_d = capture ? '0 : win_cnt_q + CW'(1);
      if (capture) win_done_d = done_post;
    end
  end

  // A pop of the head in the capture cycle makes room for the new frame.
  assign hs         = m_valid_q && m_ready;
  assign fifo_pop   = hs && m_last_q;
  assign fifo_push  = capture && (|frame_new.vmask) && (!fifo_full || fifo_pop);
  assign overflow_d = overflow_q ||
                      (capture && (|frame_new.vmask) && fifo_full && !fifo_pop);

  hwa_frame_fifo #(
    .W     ($bits(frame_t)),
    .DEPTH (FDEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .data_i  (frame_new),
    .pop_i   (fifo_pop),
    .data_o  (frame_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The head frame stays in the FIFO while it is being serialized; the
  // entry is released on the m_last handshake, and the next head is picked
  // up one cycle later.
  always_comb begin
    m_valid_d  = m_valid_q;
    m_chan_d   = m_chan_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    load       = 1'b0;
    next_chan  = '0;
    upper_mask = ~((NCH'(2) << m_chan_q) - NCH'(1));
    if (!m_valid_q) begin
      if (!fifo_empty) begin
        load      = 1'b1;
        next_chan = lowest_set(frame_head.vmask);
      end
    end else if (hs) begin
      if (m_last_q) begin
        m_valid_d = 1'b0;
      end else begin
        load      = 1'b1;
        next_chan = lowest_set(frame_head.vmask & upper_mask);
      end
    end
    if (load) begin
      m_valid_d = 1'b1;
      m_chan_d  = next_chan;
      m_data_d  = frame_head.samp[next_chan];
      m_last_d  = (next_chan == highest_set(frame_head.vmask));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt_q  <= '0;
      win_done_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_chan_q   <= '0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      win_done_q <= win_done_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      m_valid_q  <= m_valid_d;
      m_chan_q   <= m_chan_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_chan   = m_chan_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_hwa_out_collector.sv
//==============================================================================
// Module   : tb_hwa_out_collector
// Purpose  : Self-checking bench for hwa_out_collector. A queue-based model
//            tracks windows, warm-up, frame drops and the expected sample
//            stream; stimulus counts and consumer ready are randomized.
// Config   : HWA_OUT_SAT_EN - must match the RTL build.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hwa_out_collector;

  localparam int N    = 12;
  localparam int WIN  = 4096;
  localparam int NCH  = 4;
  localparam int HALF = 1 << (N - 1);

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [NCH*(N+1)-1:0] hwa_out;
  logic                 m_valid;
  logic                 m_ready;
  logic [1:0]           m_chan;
  logic signed [N:0]    m_data;
  logic                 m_last;
  logic                 busy;
  logic                 overflow;

  always #5 clock = ~clock;

  hwa_out_collector #(.N(N), .WIN(WIN), .FDEPTH(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .hwa_out  (hwa_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_chan   (m_chan),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .overflow (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int chan; int data; bit last; } exp_samp_t;
  exp_samp_t exp_q[$];

  bit  running = 0;
  int  phase = 0;      // window position of the current cycle
  int  done = 0;       // completed windows since start, saturating at 4
  int  occ = 0;        // frames held (including the one being emitted)
  bit  ovf_exp = 0;
  int  lat = -1;
  int  hs_total = 0;
  bit  prev_stall = 0;
  logic [1:0]        prev_chan;
  logic signed [N:0] prev_data;
  logic              prev_last;
  bit  mon_hs, mon_last_pop;

  function automatic int dec(input int cnt);
    int v;
    v = cnt - HALF;
`ifdef HWA_OUT_SAT_EN
    if (v > HALF - 1) v = HALF - 1;
`endif
    return v;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      running = 0; phase = 0; done = 0; occ = 0;
      ovf_exp = 0; lat = -1; prev_stall = 0;
    end else begin
      check("busy", busy, running);
      check("overflow", overflow, ovf_exp);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", m_valid, 0);
        end else begin
          check("m_chan", m_chan, exp_q[0].chan);
          check("m_data", $signed(m_data), exp_q[0].data);
          check("m_last", m_last, exp_q[0].last);
        end
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_chan", m_chan, prev_chan);
        check("stall_data", $signed(m_data), $signed(prev_data));
        check("stall_last", m_last, prev_last);
      end
      if (lat >= 0) begin
        lat++;
        if (lat == 1) check("latency_early", m_valid, 0);
        else begin
          check("latency_first", m_valid, 1);
          lat = -1;
        end
      end
      mon_hs = m_valid && m_ready;
      mon_last_pop = 0;
      if (mon_hs) begin
        hs_total++;
        if (exp_q.size() > 0) begin
          mon_last_pop = exp_q[0].last;
          void'(exp_q.pop_front());
          if (mon_last_pop) occ--;
        end
      end
      if (running && phase == WIN - 1) begin
        done = (done < 4) ? done + 1 : 4;
        if (occ < 4) begin
          if (occ == 0 && !mon_hs) lat = 0;
          occ++;
          for (int c = 0; c < NCH; c++) begin
            if (c < done)
              exp_q.push_back('{c, dec(int'(hwa_out[c*(N+1) +: N+1])), c == done - 1});
          end
        end else begin
          ovf_exp = 1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_chan  = m_chan;
      prev_data  = m_data;
      prev_last  = m_last;
      if (start) begin
        running = 1; phase = 0; done = 0;
      end else if (running) begin
        phase = (phase == WIN - 1) ? 0 : phase + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  int mode = 1;  // 0 random ready, 1 ready low, 2 ready high, 3 ready only at capture

  task automatic step();
    @(posedge clock);
    #1;
    case (mode)
      0:       m_ready = ($urandom_range(0, 3) != 0);
      1:       m_ready = 1'b0;
      2:       m_ready = 1'b1;
      default: m_ready = running && (phase == WIN - 1);
    endcase
  endtask

  task automatic wait_phase(input int p, input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(running && phase == p) && k < 2 * WIN + 8);
    if (!(running && phase == p)) check({"timeout_", tag}, phase, p);
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < 300) begin
      step();
      k++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
  endtask

  task automatic set_all(input int cnt);
    for (int c = 0; c < NCH; c++) hwa_out[c*(N+1) +: N+1] = (N+1)'(cnt);
  endtask

  task automatic set_random();
    for (int c = 0; c < NCH; c++)
      hwa_out[c*(N+1) +: N+1] = (N+1)'($urandom_range(0, 4096));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_chan"}, m_chan, 0);
    check({tag, "_m_data"}, $signed(m_data), 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int k;
    int base;
    reset_n = 1'b0;
    start   = 1'b0;
    m_ready = 1'b0;
    set_all(HALF);
    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (4) step();

    // Warm-up at mid-scale, then decode corners, then random counts.
    mode = 2;
    pulse_start();
    for (int w = 1; w <= 6; w++) begin
      wait_phase(WIN / 2, "warm");
      if (w == 5) begin
        hwa_out[0*(N+1) +: N+1] = (N+1)'(0);
        hwa_out[1*(N+1) +: N+1] = (N+1)'(4096);
        hwa_out[2*(N+1) +: N+1] = (N+1)'(1024);
        hwa_out[3*(N+1) +: N+1] = (N+1)'(3072);
      end else if (w == 6) begin
        set_random();
        mode = 0;
      end
    end
    wait_phase(WIN - 1, "cap6");
    mode = 2;
    wait_empty("warm");

    // Backpressure for five windows: four frames kept, the fifth dropped.
    mode = 1;
    for (int w = 0; w < 5; w++) begin
      wait_phase(WIN / 2, "bp");
      set_random();
      wait_phase(WIN - 1, "bp_cap");
    end
    step();
    step();
    check("bp_overflow", overflow, 1);
    check("bp_valid_held", m_valid, 1);

    // Release, then reset asynchronously in the middle of the drain.
    mode = 0;
    base = hs_total;
    k = 0;
    while (!(hs_total >= base + 6 && m_valid) && k < 300) begin
      step();
      k++;
    end
    check("arst_setup_valid", m_valid, 1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("arst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    mode = 2;
    repeat (300) step();
    check("idle_busy", busy, 0);
    check("idle_valid", m_valid, 0);

    // Fill the FIFO, then complete the head handshake in the capture cycle.
    mode = 1;
    set_random();
    pulse_start();
    for (int w = 0; w < 4; w++) begin
      wait_phase(WIN / 2, "fill");
      set_random();
      wait_phase(WIN - 1, "fill_cap");
    end
    wait_phase(WIN / 2, "fp");
    set_random();
    mode = 3;
    wait_phase(WIN - 1, "fp_cap");
    mode = 1;
    step();
    step();
    check("fp_overflow", overflow, 0);

    // Resynchronise mid-window while frames are still queued.
    wait_phase(1000, "rs");
    start = 1'b1;
    step();
    start = 1'b0;
    mode = 0;
    wait_phase(WIN / 2, "rs_mid");
    set_random();
    wait_phase(WIN - 1, "rs_cap");
    mode = 2;
    step();
    wait_empty("final");
    repeat (5) step();
    check("final_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
